// File: rtl/plab4_net_router_input_ctrl_buf_if.sv
// Handshake bundle between the input channel, the router input controller
// and the output arbiters. The controller is the slave side.
interface plab4_net_router_input_ctrl_buf_if #(
  parameter int p_num_routers = 8,
  parameter int p_depth       = 4
);
  localparam int c_dest_nbits = (p_num_routers > 1) ? $clog2(p_num_routers) : 1;
  localparam int c_cnt_nbits  = $clog2(p_depth + 1);

  logic                    in_val;
  logic                    in_rdy;
  logic [c_dest_nbits-1:0] in_dest;
  logic                    in_tail;
  logic [2:0]              reqs;
  logic [2:0]              grants;
  logic                    deq;
  logic [c_cnt_nbits-1:0]  count;

  modport master (
    output in_val, in_dest, in_tail, grants,
    input  in_rdy, reqs, deq, count
  );

  modport slave (
    input  in_val, in_dest, in_tail, grants,
    output in_rdy, reqs, deq, count
  );
endinterface

// File: rtl/plab4_net_router_input_ctrl_buf.sv
// Ring router input controller with a small queue of flit metadata.
// Routes the head flit (shortest path or fixed one-way request), requests
// the chosen output and holds a wormhole lock from head flit to tail flit.
module plab4_net_router_input_ctrl_buf #(
  parameter int         p_router_id    = 0,
  parameter int         p_num_routers  = 8,
  parameter int         p_depth        = 4,
  parameter int         p_oneway       = 0,
  parameter logic [2:0] p_default_reqs = 3'b001
) (
  input logic clk,
  input logic reset,
  input logic domain_ID,
  plab4_net_router_input_ctrl_buf_if.slave bus
);

  localparam int c_dest_nbits = (p_num_routers > 1) ? $clog2(p_num_routers) : 1;
  localparam int c_cnt_nbits  = $clog2(p_depth + 1);
  localparam int c_ptr_nbits  = $clog2(p_depth);

  localparam logic [c_ptr_nbits-1:0]  c_lastPtr = c_ptr_nbits'(p_depth - 1);
  localparam logic [c_cnt_nbits-1:0]  c_depth   = c_cnt_nbits'(p_depth);
  localparam logic [c_dest_nbits:0]   c_id      = (c_dest_nbits + 1)'(p_router_id);
  localparam logic [c_dest_nbits:0]   c_num     = (c_dest_nbits + 1)'(p_num_routers);
  localparam logic [c_dest_nbits:0]   c_half    = (c_dest_nbits + 1)'(p_num_routers / 2);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_q;
  logic [2:0]              lock_q;
  logic [c_ptr_nbits-1:0]  wrPtr_q, wrPtr_d;
  logic [c_ptr_nbits-1:0]  rdPtr_q, rdPtr_d;
  logic [c_cnt_nbits-1:0]  count_q, count_d;
  logic [c_dest_nbits-1:0] destMem_q [p_depth];
  logic                    tailMem_q [p_depth];

  logic                    empty;
  logic                    inRdy;
  logic                    enq;
  logic                    deq;
  logic [c_dest_nbits-1:0] headDest;
  logic                    headTail;
  logic [c_dest_nbits:0]   headDestX;
  logic [c_dest_nbits:0]   distance;
  logic [2:0]              route;
  logic [2:0]              reqs;

  // domain_ID only labels the ports; no logic depends on it.
  logic unused_domainId;
  assign unused_domainId = domain_ID;

  assign empty     = (count_q == '0);
  assign inRdy     = (count_q < c_depth);
  assign enq       = bus.in_val && inRdy;
  assign headDest  = destMem_q[rdPtr_q];
  assign headTail  = tailMem_q[rdPtr_q];
  assign headDestX = {1'b0, headDest};

  // Route the head flit: local delivery, fixed one-way request, or the
  // shorter ring direction with ties going clockwise.
  always_comb begin
    distance = '0;
    route    = 3'b000;
    if (headDestX >= c_id) begin
      distance = headDestX - c_id;
    end else begin
      distance = headDestX + c_num - c_id;
    end
    if (headDestX == c_id) begin
      route = 3'b010;
    end else if (p_oneway != 0) begin
      route = p_default_reqs;
    end else if (distance <= c_half) begin
      route = 3'b001;
    end else begin
      route = 3'b100;
    end
  end

  // Requests come from the route in IDLE and from the held lock mid-packet.
  always_comb begin
    reqs = 3'b000;
    if (!empty) begin
      reqs = (state_q == LOCKED) ? lock_q : route;
    end
  end

  assign deq = |(reqs & bus.grants);

  assign bus.in_rdy = inRdy;
  assign bus.reqs   = reqs;
  assign bus.deq    = deq;
  assign bus.count  = count_q;

  // Next pointer and occupancy values; pointers wrap at the queue depth.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (enq) begin
      wrPtr_d = (wrPtr_q == c_lastPtr) ? '0 : wrPtr_q + 1'b1;
    end
    if (deq) begin
      rdPtr_d = (rdPtr_q == c_lastPtr) ? '0 : rdPtr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue pointers and occupancy, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Flit metadata storage; stale entries are never read because count gates them.
  always_ff @(posedge clk) begin
    if (enq) begin
      destMem_q[wrPtr_q] <= bus.in_dest;
      tailMem_q[wrPtr_q] <= bus.in_tail;
    end
  end

  // Wormhole lock: a granted head without tail locks its output until the tail leaves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lock_q  <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (deq && !headTail) begin
            state_q <= LOCKED;
            lock_q  <= reqs;
          end
        end
        LOCKED: begin
          if (deq && headTail) begin
            state_q <= IDLE;
            lock_q  <= 3'b000;
          end
        end
        default: begin
          state_q <= IDLE;
          lock_q  <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_buf.sv
// Testbench for the ring router input controller: a bidirectional instance
// and a one-way instance, both router 2 of 8 with a 4-entry queue.
module tb_plab4_net_router_input_ctrl_buf;

  localparam int N     = 8;
  localparam int ID    = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic domainId;

  int vectors;
  int miscompares;

  plab4_net_router_input_ctrl_buf_if #(.p_num_routers(N), .p_depth(DEPTH)) bus0 ();
  plab4_net_router_input_ctrl_buf_if #(.p_num_routers(N), .p_depth(DEPTH)) bus1 ();

  plab4_net_router_input_ctrl_buf #(
    .p_router_id(ID), .p_num_routers(N), .p_depth(DEPTH),
    .p_oneway(0), .p_default_reqs(3'b001)
  ) dut0 (
    .clk(clk), .reset(reset), .domain_ID(domainId), .bus(bus0)
  );

  plab4_net_router_input_ctrl_buf #(
    .p_router_id(ID), .p_num_routers(N), .p_depth(DEPTH),
    .p_oneway(1), .p_default_reqs(3'b001)
  ) dut1 (
    .clk(clk), .reset(reset), .domain_ID(domainId), .bus(bus1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: expected request vector of each queued flit, oldest first.
  logic [2:0] expQ0[$];
  logic [2:0] expQ1[$];
  bit         inPkt0, inPkt1;
  logic [2:0] pktRoute0, pktRoute1;

  // Reference route: count clockwise hops, then pick the shorter side.
  function automatic logic [2:0] modelRoute(input int dest, input bit oneway);
    int cw;
    cw = 0;
    for (int h = 0; h < N; h++) begin
      if (((ID + h) % N) == dest) cw = h;
    end
    if (cw == 0) return 3'b010;
    if (oneway) return 3'b001;
    if (2 * cw <= N) return 3'b001;
    return 3'b100;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one flit for one edge; the model records its expected request.
  task automatic applyStimulus(input int port, input int dest, input bit tail);
    logic [2:0] r;
    if (port == 0) begin
      bus0.in_val  = 1'b1;
      bus0.in_dest = 3'(dest);
      bus0.in_tail = tail;
      checkOutput("in_rdy_enq0", 8'(bus0.in_rdy), 8'd1);
      @(posedge clk);
      r = inPkt0 ? pktRoute0 : modelRoute(dest, 1'b0);
      pktRoute0 = r;
      inPkt0 = !tail;
      expQ0.push_back(r);
      #1;
      bus0.in_val = 1'b0;
    end else begin
      bus1.in_val  = 1'b1;
      bus1.in_dest = 3'(dest);
      bus1.in_tail = tail;
      checkOutput("in_rdy_enq1", 8'(bus1.in_rdy), 8'd1);
      @(posedge clk);
      r = inPkt1 ? pktRoute1 : modelRoute(dest, 1'b1);
      pktRoute1 = r;
      inPkt1 = !tail;
      expQ1.push_back(r);
      #1;
      bus1.in_val = 1'b0;
    end
  endtask

  // Grant the expected output every cycle until the model queue is empty.
  task automatic drain(input int port);
    for (int i = 0; i < 20; i++) begin
      if (port == 0) begin
        if (expQ0.size() == 0) break;
        bus0.grants = expQ0[0];
      end else begin
        if (expQ1.size() == 0) break;
        bus1.grants = expQ1[0];
      end
      tick();
    end
    bus0.grants = 3'b000;
    bus1.grants = 3'b000;
    checkOutput("drain_done", 8'(port == 0 ? expQ0.size() : expQ1.size()), 8'd0);
  endtask

  // Monitor on the falling edge: compare occupancy, requests and dequeues
  // against the scoreboard and retire flits the model expects to leave.
  always @(negedge clk) begin
    logic expDeq;
    checkOutput("in_rdy0", 8'(bus0.in_rdy), 8'(expQ0.size() < DEPTH));
    checkOutput("count0", 8'(bus0.count), 8'(expQ0.size()));
    if (expQ0.size() == 0) begin
      checkOutput("reqs_empty0", 8'(bus0.reqs), 8'd0);
      checkOutput("deq_empty0", 8'(bus0.deq), 8'd0);
    end else begin
      expDeq = |(expQ0[0] & bus0.grants);
      checkOutput("reqs0", 8'(bus0.reqs), 8'(expQ0[0]));
      checkOutput("deq0", 8'(bus0.deq), 8'(expDeq));
      if (expDeq) void'(expQ0.pop_front());
    end
    checkOutput("count1", 8'(bus1.count), 8'(expQ1.size()));
    if (expQ1.size() == 0) begin
      checkOutput("reqs_empty1", 8'(bus1.reqs), 8'd0);
    end else begin
      expDeq = |(expQ1[0] & bus1.grants);
      checkOutput("reqs1", 8'(bus1.reqs), 8'(expQ1[0]));
      checkOutput("deq1", 8'(bus1.deq), 8'(expDeq));
      if (expDeq) void'(expQ1.pop_front());
    end
  end

  // Runaway guard so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of steps.
  initial begin
    int         dests [4];
    logic [2:0] routes[4];
    dests  = '{2, 6, 7, 3};
    routes = '{3'b010, 3'b001, 3'b100, 3'b001};

    vectors     = 0;
    miscompares = 0;
    inPkt0 = 1'b0;
    inPkt1 = 1'b0;
    pktRoute0 = 3'b000;
    pktRoute1 = 3'b000;
    domainId = 1'b0;
    reset = 1'b0;
    bus0.in_val = 1'b0; bus0.in_dest = '0; bus0.in_tail = 1'b0; bus0.grants = 3'b000;
    bus1.in_val = 1'b0; bus1.in_dest = '0; bus1.in_tail = 1'b0; bus1.grants = 3'b000;

    // Reset then idle.
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_in_rdy", 8'(bus0.in_rdy), 8'd1);
    checkOutput("rst_reqs", 8'(bus0.reqs), 8'd0);
    checkOutput("rst_count", 8'(bus0.count), 8'd0);
    checkOutput("rst_deq", 8'(bus0.deq), 8'd0);
    tick();

    // Single-flit routing, granted immediately; stray grants on an empty queue do nothing.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, dests[i], 1'b1);
      checkOutput("route", 8'(bus0.reqs), 8'(routes[i]));
      bus0.grants = routes[i];
      #1;
      checkOutput("route_deq", 8'(bus0.deq), 8'd1);
      tick();
      checkOutput("route_cnt", 8'(bus0.count), 8'd0);
      checkOutput("empty_grant_deq", 8'(bus0.deq), 8'd0);
      bus0.grants = 3'b000;
    end

    // Wrong grant leaves the queue untouched.
    applyStimulus(0, 3, 1'b1);
    bus0.grants = 3'b100;
    #1;
    checkOutput("wrong_grant_deq", 8'(bus0.deq), 8'd0);
    tick();
    checkOutput("wrong_grant_cnt", 8'(bus0.count), 8'd1);
    checkOutput("wrong_grant_reqs", 8'(bus0.reqs), 8'b001);
    bus0.grants = 3'b000;
    drain(0);

    // Wormhole packet that also fills the queue.
    applyStimulus(0, 7, 1'b0);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(0, 2, 1'b1);
    checkOutput("full_cnt", 8'(bus0.count), 8'd4);
    checkOutput("full_rdy", 8'(bus0.in_rdy), 8'd0);
    bus0.grants = 3'b100;
    #1;
    checkOutput("full_deq_rdy", 8'(bus0.in_rdy), 8'd0);
    checkOutput("head_deq", 8'(bus0.deq), 8'd1);
    tick();
    bus0.grants = 3'b000;
    checkOutput("after_full_cnt", 8'(bus0.count), 8'd3);
    checkOutput("after_full_rdy", 8'(bus0.in_rdy), 8'd1);
    checkOutput("locked_reqs", 8'(bus0.reqs), 8'b100);
    drain(0);
    applyStimulus(0, 2, 1'b1);
    checkOutput("fresh_route", 8'(bus0.reqs), 8'b010);
    drain(0);

    // Enqueue and dequeue together at count 2.
    applyStimulus(0, 3, 1'b1);
    applyStimulus(0, 3, 1'b1);
    bus0.grants = 3'b001;
    applyStimulus(0, 7, 1'b1);
    bus0.grants = 3'b000;
    checkOutput("enq_deq_cnt", 8'(bus0.count), 8'd2);
    drain(0);

    // Reset in the middle of a locked packet.
    applyStimulus(0, 7, 1'b0);
    applyStimulus(0, 2, 1'b0);
    bus0.grants = 3'b100;
    tick();
    bus0.grants = 3'b000;
    checkOutput("mid_locked_reqs", 8'(bus0.reqs), 8'b100);
    reset = 1'b0;
    expQ0.delete();
    inPkt0 = 1'b0;
    #1;
    checkOutput("async_rst_cnt", 8'(bus0.count), 8'd0);
    checkOutput("async_rst_reqs", 8'(bus0.reqs), 8'd0);
    checkOutput("async_rst_rdy", 8'(bus0.in_rdy), 8'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("post_rst_rdy", 8'(bus0.in_rdy), 8'd1);
    applyStimulus(0, 2, 1'b1);
    checkOutput("post_rst_route", 8'(bus0.reqs), 8'b010);
    drain(0);

    // One-way instance.
    applyStimulus(1, 7, 1'b1);
    checkOutput("oneway_d7", 8'(bus1.reqs), 8'b001);
    drain(1);
    applyStimulus(1, 2, 1'b1);
    checkOutput("oneway_d2", 8'(bus1.reqs), 8'b010);
    drain(1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_input_ctrl_buf.md
Name: plab4_net_router_input_ctrl_buf

Overview:
- Next-generation router input controller for the ring network.
- Adds a p_depth-entry input queue for flit routing metadata (dest, tail).
- Selects the output port by shortest-path bidirectional ring routing, or a fixed default in one-way mode.
- Holds a wormhole lock on the granted output from head flit to tail flit.
- Sits between the input channel and the router's output arbiters: drives per-output requests and consumes the arbiters' grants.

Parameters:
- p_router_id, 0, this router's ID.
- p_num_routers, 8, routers on the ring; c_dest_nbits = $clog2(p_num_routers).
- p_depth, 4, queue entries (>=2, any integer).
- p_oneway, 0, 1 = every non-local flit requests p_default_reqs; 0 = shortest-path routing.
- p_default_reqs, 3'b001, output request vector used in one-way mode.
- c_cnt_nbits, $clog2(p_depth+1), occupancy width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- domain_ID  in  1  security domain; every other port is labelled {Domain domain_ID}.
- in_val  in  1  incoming flit valid.
- in_rdy  out  1  queue can accept a flit.
- in_dest  in  c_dest_nbits  destination router of the incoming flit (meaningful on head flits).
- in_tail  in  1  incoming flit is the last flit of its packet.
- reqs  out  3  output requests: bit0 = clockwise, bit1 = terminal, bit2 = counter-clockwise.
- grants  in  3  one-hot grants from the output arbiters.
- deq  out  1  head flit leaves this cycle.
- count  out  c_cnt_nbits  current queue occupancy.

Behaviour:
- Reset (asynchronous, while reset==0): count=0, pointers=0, state=IDLE, lock=3'b000. Consequently reqs=0, deq=0, in_rdy=1.
- Enqueue: occurs on the posedge where in_val && in_rdy. in_rdy = (count < p_depth), computed combinationally from registered state. There is no pass-through when full: in_rdy=0 even if a dequeue happens in the same cycle.
- Latency: a flit enqueued at edge t is at the head and can request in the cycle after edge t. There is no same-cycle bypass.
- Pointers wrap modulo p_depth. Simultaneous enqueue and dequeue leave count unchanged.
- Route function, applied to the head flit in IDLE:
  - head.dest == p_router_id -> 3'b010.
  - Otherwise, if p_oneway -> p_default_reqs.
  - Otherwise d = (head.dest - p_router_id) mod p_num_routers. d <= p_num_routers/2 -> 3'b001 (ties go clockwise); else 3'b100.
- reqs = 0 when the queue is empty. Otherwise reqs = route(head) in IDLE, or reqs = lock in LOCKED. In LOCKED the head dest is ignored.
- deq = |(reqs & grants). Grant bits outside reqs are ignored. Grants arriving while the queue is empty cause no effect.
- FSM:
  - IDLE -> LOCKED on deq && !head.tail; lock <= reqs.
  - LOCKED -> IDLE on deq && head.tail; lock <= 0.
  - A single-flit packet (head.tail=1) is dequeued while staying in IDLE.
  - All other cycles: state holds.
- Reset asserted mid-packet: the lock, the FSM and all queue contents are discarded immediately. in_rdy is 1 on the first cycle after release.
- All outputs are combinational from registered state plus grants; there is no input-to-output path from in_val or in_dest.

Test Plan:
- Reset then idle: after release, in_rdy=1, reqs=0, count=0. Assert reset for 1 cycle mid-LOCKED -> state IDLE, count=0 without waiting for a clock edge.
- Routing, id=2, N=8, p_oneway=0: single-flit dest=2 -> 3'b010; dest=6 (d=4, tie) -> 3'b001; dest=7 (d=5) -> 3'b100; dest=3 -> 3'b001. Grant each -> deq=1 for one cycle.
- One-way mode, p_oneway=1, id=2: dest=7 -> reqs=3'b001; dest=2 -> 3'b010.
- Wormhole, id=2: head dest=7 (tail=0) granted on bit2 -> LOCKED. Two body flits with dest=2 -> reqs stays 3'b100. Tail dequeue -> IDLE. Next packet routes fresh.
- Full/backpressure, p_depth=4: enqueue 4 flits with grants=0 -> count=4, in_rdy=0. Grant one -> count=3 next cycle and in_rdy=1 only then. Enqueue and dequeue together at count=2 -> count stays 2.
- Wrong grant: reqs=3'b001 with grants=3'b100 -> deq=0, queue unchanged.
